altivec_issue_queue: RTL and testbench
======================================

Name: altivec_issue_queue

Overview:
Issue stage directly upstream of altivec_dut_wrapper. Buffers decoded AltiVec instruction/operand bundles in a small FIFO, classifies each instruction, and drives vra/vrb/vrc/ins/rc with a one-cycle go1/go2/go3 pulse. Issues one instruction at a time and holds operands stable until the vector unit releases dut_busy. Drops non-AltiVec opcodes and flags them.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
ACK_WIN, 2, cycles to wait for dut_busy to rise after a go pulse before treating the op as single-cycle complete; at least 1.
CNT_W, 16, width of the issued-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low.
in_valid  in  1  upstream bundle valid.
in_ready  out  1  queue can accept a bundle.
in_ins  in  32  instruction word.
in_vra  in  128  operand A.
in_vrb  in  128  operand B.
in_vrc  in  128  operand C.
dut_busy  in  1  vector unit busy.
vra  out  128  operand A to the vector unit.
vrb  out  128  operand B to the vector unit.
vrc  out  128  operand C to the vector unit.
ins  out  32  instruction to the vector unit.
rc  out  1  record bit; equals ins[10] for go2 ops, otherwise 0.
go1  out  1  issue pulse, VX-form op.
go2  out  1  issue pulse, VC-form (compare) op.
go3  out  1  issue pulse, VA-form (three-operand) op.
fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
illegal  out  1  one-cycle pulse when a bundle is discarded.
issued_cnt  out  CNT_W  count of completed issues; wraps modulo 2^CNT_W.

Behaviour:
- Reset, rst low, takes effect at once: FIFO is emptied (fill=0), FSM goes to IDLE, and in_ready=0 while rst is low. vra, vrb, vrc, ins, rc, go1, go2, go3, illegal and issued_cnt are all 0. Reset in the middle of an op abandons it; no go is issued and dut_busy is ignored.
- Push: in_valid && in_ready in a cycle writes the bundle at the tail. in_ready = !full. There is no pass-through when full, even if a pop happens in the same cycle.
- Simultaneous push and pop in one cycle: fill is unchanged. Pointers wrap modulo DEPTH.
- Classification at the head entry:
  - in_ins[31:26] != 6'd4 → illegal.
  - else ins[5]=1 → go3.
  - else ins[10]=1 → go2.
  - else go1.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head.
    - Illegal head: discard it, pulse illegal for 1 cycle, stay in IDLE, issued_cnt unchanged.
    - Legal head: latch it into the output registers → GO.
  - GO (1 cycle): assert exactly one of go1/go2/go3 → ACK, with wait counter = 0.
  - ACK:
    - dut_busy=1 → EXEC.
    - else increment the wait counter; when it reaches ACK_WIN → DONE.
  - EXEC: hold while dut_busy=1; dut_busy=0 → DONE.
  - DONE (1 cycle): issued_cnt += 1 → IDLE.
- Latency: a bundle pushed into an empty, idle queue at cycle T is popped at T+1 and its go pulse appears at T+2. The minimum issue interval is ACK_WIN+3 cycles.
- vra, vrb, vrc, ins and rc stay stable from GO through DONE and keep their value in IDLE until the next latch.
- If dut_busy is already 1 in IDLE, the FSM does not pop; issue waits for dut_busy=0.
- go1, go2 and go3 are mutually exclusive and never asserted outside GO.

Test Plan:
- Reset, then push ins=0x1000_0020 (op 4, ins[5]=1) with vra=1, vrb=2, vrc=3. dut_busy rises one cycle after go and stays high 5 cycles → go3 pulses at T+2; vra/vrb/vrc/ins are stable until DONE; issued_cnt=1.
- Push ins=0x1000_0406 (ins[10]=1). dut_busy never rises → go2=1 and rc=1; DONE after ACK_WIN=2 cycles; issued_cnt increments.
- Push ins=0x7C00_0000 → no go pulse; illegal pulses for 1 cycle; fill returns to 0; issued_cnt unchanged.
- Push 5 bundles back-to-back while dut_busy is held high → in_ready=0 once fill=4. After dut_busy drops, bundles issue in order with go1 only for ins=0x1000_0000; all 5 complete.
- Assert rst low while in EXEC with fill=3 → fill=0, all outputs 0, no further go after rst rises; a fresh push issues normally.
- Preload issued_cnt to 0xFFFF by running 65535 single-cycle ops (or force), then run one more op → issued_cnt wraps to 0.

Source files
------------

// File: rtl/altivec_issue_queue.sv
// AltiVec issue stage: FIFO-buffered bundles, head classification, one op in flight with go1/go2/go3.
// Push-to-go is 2 cycles on an idle queue; in_ready = !full with no pass-through when full.

module altivec_iq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Callers qualify push with !full and pop with !empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign fill    = count;
endmodule

module altivec_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ACK_WIN = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ins,
  input  logic [127:0]             in_vra,
  input  logic [127:0]             in_vrb,
  input  logic [127:0]             in_vrc,
  input  logic                     dut_busy,
  output logic [127:0]             vra,
  output logic [127:0]             vrb,
  output logic [127:0]             vrc,
  output logic [31:0]              ins,
  output logic                     rc,
  output logic                     go1,
  output logic                     go2,
  output logic                     go3,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     illegal,
  output logic [CNT_W-1:0]         issued_cnt
);
  localparam int WW = $clog2(ACK_WIN + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_WIN - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef struct packed {
    logic [31:0]  ins;
    logic [127:0] vra;
    logic [127:0] vrb;
    logic [127:0] vrc;
  } bundle_t;

  typedef enum logic [2:0] {S_IDLE, S_GO, S_ACK, S_EXEC, S_DONE} state_t;

  state_t        state, state_nxt;
  bundle_t       in_bundle, head;
  logic          empty, full, push, pop;
  logic          head_illegal, head_is3, head_is2;
  logic          kind3, kind2;
  logic [WW-1:0] wait_cnt;

  assign in_bundle = '{ins: in_ins, vra: in_vra, vrb: in_vrb, vrc: in_vrc};

  // in_ready is forced low during reset, not just via the cleared FIFO.
  assign in_ready = rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && !empty && !dut_busy;

  altivec_iq_fifo #(.W($bits(bundle_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (in_bundle),
    .pop      (pop),
    .pop_dat  (head),
    .empty    (empty),
    .full     (full),
    .fill     (fill)
  );

  assign head_illegal = (head.ins[31:26] != 6'd4);
  assign head_is3     = head.ins[5];
  assign head_is2     = !head.ins[5] && head.ins[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go1       = 1'b0;
    go2       = 1'b0;
    go3       = 1'b0;
    case (state)
      S_IDLE: if (pop && !head_illegal) state_nxt = S_GO;
      S_GO: begin
        go3       = kind3;
        go2       = kind2;
        go1       = !kind3 && !kind2;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        if (dut_busy)                   state_nxt = S_EXEC;
        else if (wait_cnt == WAIT_LAST) state_nxt = S_DONE;
      end
      S_EXEC: if (!dut_busy) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/instruction registers load only on a legal pop and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vra        <= '0;
      vrb        <= '0;
      vrc        <= '0;
      ins        <= '0;
      rc         <= 1'b0;
      kind3      <= 1'b0;
      kind2      <= 1'b0;
      illegal    <= 1'b0;
      wait_cnt   <= '0;
      issued_cnt <= '0;
    end else begin
      illegal <= pop && head_illegal;
      if (pop && !head_illegal) begin
        vra   <= head.vra;
        vrb   <= head.vrb;
        vrc   <= head.vrc;
        ins   <= head.ins;
        rc    <= head_is2;
        kind3 <= head_is3;
        kind2 <= head_is2;
      end
      if (state == S_GO)                  wait_cnt <= '0;
      else if (state == S_ACK && !dut_busy) wait_cnt <= wait_cnt + WAIT_ONE;
      if (state == S_DONE) issued_cnt <= issued_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_altivec_issue_queue.sv
// Directed bench for altivec_issue_queue; a second small instance exercises counter wrap.
module tb_altivec_issue_queue;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_valid2;
  logic         in_ready, in_ready2;
  logic [31:0]  in_ins;
  logic [127:0] in_vra, in_vrb, in_vrc;
  logic         dut_busy;
  logic [127:0] vra, vrb, vrc, vra2, vrb2, vrc2;
  logic [31:0]  ins, ins2;
  logic         rc, go1, go2, go3, rc2, g1b, g2b, g3b;
  logic [2:0]   fill;
  logic [1:0]   fill2;
  logic         illegal, illegal2;
  logic [15:0]  issued_cnt;
  logic [3:0]   issued_cnt2;

  int pass = 0;
  int chk  = 0;
  int go_multi = 0;

  typedef struct packed {
    logic [2:0]   g;
    logic [31:0]  i;
    logic [127:0] a;
  } ev_t;
  ev_t evq[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  altivec_issue_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_vra(in_vra), .in_vrb(in_vrb), .in_vrc(in_vrc),
    .dut_busy(dut_busy), .vra(vra), .vrb(vrb), .vrc(vrc), .ins(ins), .rc(rc),
    .go1(go1), .go2(go2), .go3(go3), .fill(fill), .illegal(illegal),
    .issued_cnt(issued_cnt)
  );

  altivec_issue_queue #(.DEPTH(2), .ACK_WIN(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_ins(in_ins), .in_vra(in_vra), .in_vrb(in_vrb), .in_vrc(in_vrc),
    .dut_busy(1'b0), .vra(vra2), .vrb(vrb2), .vrc(vrc2), .ins(ins2), .rc(rc2),
    .go1(g1b), .go2(g2b), .go3(g3b), .fill(fill2), .illegal(illegal2),
    .issued_cnt(issued_cnt2)
  );

  always @(negedge clk) begin
    if (go1 || go2 || go3) begin
      mon_e.g = {go1, go2, go3};
      mon_e.i = ins;
      mon_e.a = vra;
      evq.push_back(mon_e);
    end
    if (int'(go1) + int'(go2) + int'(go3) > 1) go_multi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [127:0] a, b, c);
    in_valid = 1'b1; in_ins = i; in_vra = a; in_vrb = b; in_vrc = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 0; in_valid2 = 0; dut_busy = 0;
    in_ins = '0; in_vra = '0; in_vrb = '0; in_vrc = '0;
    tick(); tick();
    chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass++;
    chk++; if (fill !== 3'd0) $display("FAIL reset_fill: got %0d want 0", fill); else pass++;
    chk++; if ({go1, go2, go3, illegal, rc} !== 5'b0) $display("FAIL reset_pulses: got %b want 0", {go1, go2, go3, illegal, rc}); else pass++;
    chk++; if (issued_cnt !== 16'd0 || ins !== 32'd0 || vra !== '0) $display("FAIL reset_regs: cnt %h ins %h vra %h want 0", issued_cnt, ins, vra); else pass++;
    rst = 1'b1;
    tick();
    chk++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", in_ready); else pass++;
  endtask

  task automatic test_go3_busy();
    push(32'h1000_0020, 128'd1, 128'd2, 128'd3);
    chk++; if (fill !== 3'd1) $display("FAIL go3_fill_t1: got %0d want 1", fill); else pass++;
    tick();
    chk++; if ({go1, go2, go3} !== 3'b001) $display("FAIL go3_pulse_t2: got %b want 001", {go1, go2, go3}); else pass++;
    chk++; if (vra !== 128'd1 || vrb !== 128'd2 || vrc !== 128'd3 || ins !== 32'h1000_0020 || rc !== 1'b0)
      $display("FAIL go3_operands: vra %0h vrb %0h vrc %0h ins %h rc %b", vra, vrb, vrc, ins, rc); else pass++;
    tick();
    dut_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk++; if ({go1, go2, go3} !== 3'b000 || vra !== 128'd1 || vrc !== 128'd3 || ins !== 32'h1000_0020)
        $display("FAIL go3_hold_%0d: go %b vra %0h vrc %0h ins %h", k, {go1, go2, go3}, vra, vrc, ins); else pass++;
      tick();
    end
    dut_busy = 1'b0;
    tick();
    chk++; if (issued_cnt !== 16'd0 || vrb !== 128'd2) $display("FAIL go3_done_cnt: cnt %0d vrb %0h want 0/2", issued_cnt, vrb); else pass++;
    tick();
    chk++; if (issued_cnt !== 16'd1) $display("FAIL go3_cnt: got %0d want 1", issued_cnt); else pass++;
  endtask

  task automatic test_go2_timeout();
    push(32'h1000_0406, 128'h11, 128'h22, 128'h33);
    tick();
    chk++; if ({go1, go2, go3} !== 3'b010 || rc !== 1'b1) $display("FAIL go2_pulse: go %b rc %b want 010/1", {go1, go2, go3}, rc); else pass++;
    tick(); tick(); tick();
    chk++; if (issued_cnt !== 16'd1 || rc !== 1'b1) $display("FAIL go2_done_cycle: cnt %0d rc %b want 1/1", issued_cnt, rc); else pass++;
    tick();
    chk++; if (issued_cnt !== 16'd2) $display("FAIL go2_cnt: got %0d want 2", issued_cnt); else pass++;
  endtask

  task automatic test_illegal();
    evq.delete();
    push(32'h7C00_0000, 128'h5, 128'h6, 128'h7);
    chk++; if (fill !== 3'd1 || illegal !== 1'b0) $display("FAIL ill_t1: fill %0d illegal %b want 1/0", fill, illegal); else pass++;
    tick();
    chk++; if (illegal !== 1'b1 || fill !== 3'd0) $display("FAIL ill_pulse: illegal %b fill %0d want 1/0", illegal, fill); else pass++;
    tick();
    chk++; if (illegal !== 1'b0) $display("FAIL ill_width: got %b want 0", illegal); else pass++;
    tick(); tick(); tick();
    chk++; if (evq.size() != 0 || issued_cnt !== 16'd2 || ins !== 32'h1000_0406)
      $display("FAIL ill_no_issue: gos %0d cnt %0d ins %h", evq.size(), issued_cnt, ins); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] bi [5];
    logic [2:0]  bg [5];
    int budget;
    bi[0] = 32'h1000_0000; bg[0] = 3'b100;
    bi[1] = 32'h1000_0020; bg[1] = 3'b001;
    bi[2] = 32'h1000_0400; bg[2] = 3'b010;
    bi[3] = 32'h1000_0420; bg[3] = 3'b001;
    bi[4] = 32'h1000_0460; bg[4] = 3'b001;
    evq.delete();
    dut_busy = 1'b1;
    for (int k = 0; k < 4; k++) push(bi[k], 128'(k + 10), '0, '0);
    chk++; if (fill !== 3'd4 || in_ready !== 1'b0) $display("FAIL b2b_full: fill %0d ready %b want 4/0", fill, in_ready); else pass++;
    in_valid = 1'b1; in_ins = bi[4]; in_vra = 128'd14;
    tick(); tick();
    chk++; if (fill !== 3'd4 || evq.size() != 0) $display("FAIL b2b_busy_hold: fill %0d gos %0d want 4/0", fill, evq.size()); else pass++;
    dut_busy = 1'b0;
    #1;
    chk++; if (in_ready !== 1'b0) $display("FAIL b2b_no_passthru: ready %b want 0", in_ready); else pass++;
    tick();
    chk++; if (fill !== 3'd3) $display("FAIL b2b_pop_fill: got %0d want 3", fill); else pass++;
    budget = 10;
    while (!in_ready && budget > 0) begin tick(); budget--; end
    tick();
    in_valid = 1'b0;
    budget = 60;
    while (issued_cnt !== 16'd7 && budget > 0) begin tick(); budget--; end
    chk++; if (issued_cnt !== 16'd7) $display("FAIL b2b_complete: cnt %0d want 7", issued_cnt); else pass++;
    chk++; if (evq.size() != 5) $display("FAIL b2b_go_count: got %0d want 5", evq.size()); else pass++;
    for (int k = 0; k < 5 && k < evq.size(); k++) begin
      chk++; if (evq[k].i !== bi[k] || evq[k].g !== bg[k] || evq[k].a !== 128'(k + 10))
        $display("FAIL b2b_order_%0d: ins %h go %b vra %0h want %h %b %0h", k, evq[k].i, evq[k].g, evq[k].a, bi[k], bg[k], k + 10); else pass++;
    end
  endtask

  task automatic test_reset_mid();
    push(32'h1000_0000, 128'hA, '0, '0);
    push(32'h1000_0000, 128'hB, '0, '0);
    dut_busy = 1'b1;
    push(32'h1000_0000, 128'hC, '0, '0);
    push(32'h1000_0000, 128'hD, '0, '0);
    chk++; if (fill !== 3'd3 || vra !== 128'hA) $display("FAIL mid_pre: fill %0d vra %0h want 3/a", fill, vra); else pass++;
    rst = 1'b0;
    #1;
    evq.delete();
    chk++; if (fill !== 3'd0 || in_ready !== 1'b0 || issued_cnt !== 16'd0 || vra !== '0 || ins !== 32'd0)
      $display("FAIL mid_reset: fill %0d ready %b cnt %0d vra %0h ins %h", fill, in_ready, issued_cnt, vra, ins); else pass++;
    tick(); tick();
    rst = 1'b1;
    dut_busy = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk++; if (evq.size() != 0 || issued_cnt !== 16'd0) $display("FAIL mid_no_go: gos %0d cnt %0d want 0/0", evq.size(), issued_cnt); else pass++;
    push(32'h1000_0400, 128'hE, '0, '0);
    tick();
    chk++; if ({go1, go2, go3} !== 3'b010 || vra !== 128'hE) $display("FAIL mid_fresh_go: go %b vra %0h want 010/e", {go1, go2, go3}, vra); else pass++;
    for (int k = 0; k < 4; k++) tick();
    chk++; if (issued_cnt !== 16'd1) $display("FAIL mid_fresh_cnt: got %0d want 1", issued_cnt); else pass++;
  endtask

  task automatic test_wrap();
    in_ins = 32'h1000_0000;
    for (int n = 1; n <= 16; n++) begin
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      if (n == 15) begin
        chk++; if (issued_cnt2 !== 4'hF) $display("FAIL wrap_pre: got %h want f", issued_cnt2); else pass++;
      end
    end
    chk++; if (issued_cnt2 !== 4'h0) $display("FAIL wrap_cnt: got %h want 0", issued_cnt2); else pass++;
  endtask

  initial begin
    test_reset();
    test_go3_busy();
    test_go2_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    chk++; if (go_multi != 0) $display("FAIL go_exclusive: %0d overlapping cycles", go_multi); else pass++;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
